// File: rtl/ulpi_packet_tx.sv
// ULPI link-side USB packet transmitter: sends handshake PIDs and data packets
// (TX CMD, FIFO payload, CRC16) and owns the ULPI data bus only while ulpi_oe is high.
module ulpi_packet_tx #(
  parameter int MAX_LEN = 1023,
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic          USB_CLKIN,
  input  logic          RST,
  input  logic          ulpi_dir,
  input  logic          ulpi_nxt,
  output logic [7:0]    ulpi_data_o,
  output logic          ulpi_oe,
  output logic          ulpi_stp,
  input  logic          tx_start,
  input  logic [3:0]    tx_pid,
  input  logic [LW-1:0] tx_len,
  input  logic [7:0]    data_i,
  input  logic          data_i_empty,
  output logic          data_i_rd,
  output logic          tx_busy,
  output logic          tx_done,
  output logic          tx_abort,
  output logic          tx_err,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {IDLE, TXCMD, PAYLOAD, CRC_LO, CRC_HI, STOP} state_t;

  state_t         state, state_n;
  logic           dir_q;
  logic [3:0]     pid_q;
  logic [LW-1:0]  len_q;
  logic           is_data_q;
  logic [LW-1:0]  count;
  logic [15:0]    crc;
  logic           done_q, abort_q, err_q;
  logic           accept, bad_pid, take, abort_n, underrun, done_n;
  logic           pid_hs, pid_data;

  // Reflected CRC16 (poly 0xA001), one byte processed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  // All handshake PIDs end in 2'b10, all data PIDs in 2'b11.
  assign pid_hs   = (tx_pid[1:0] == 2'b10);
  assign pid_data = (tx_pid[1:0] == 2'b11);

  always_ff @(posedge USB_CLKIN or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      dir_q     <= 1'b0;
      pid_q     <= 4'h0;
      len_q     <= '0;
      is_data_q <= 1'b0;
      count     <= '0;
      crc       <= 16'hFFFF;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state   <= state_n;
      dir_q   <= ulpi_dir;
      done_q  <= done_n;
      abort_q <= abort_n;
      err_q   <= underrun | bad_pid;
      if (accept) begin
        pid_q     <= tx_pid;
        len_q     <= tx_len;
        is_data_q <= pid_data;
        count     <= '0;
        crc       <= 16'hFFFF;
      end else if (take) begin
        count <= count + LW'(1);
        crc   <= crc16_byte(crc, data_i);
      end
    end
  end

  // Handshake: the byte on ulpi_data_o is offered while ulpi_oe=1 and transfers
  // in any cycle with ulpi_nxt=1 (nxt acts as ready); it is held otherwise.
  // data_i_rd pops the FIFO only in a cycle where a payload byte transfers.
  always_comb begin
    state_n     = state;
    ulpi_data_o = 8'h00;
    ulpi_oe     = 1'b0;
    ulpi_stp    = 1'b0;
    data_i_rd   = 1'b0;
    accept      = 1'b0;
    bad_pid     = 1'b0;
    take        = 1'b0;
    abort_n     = 1'b0;
    underrun    = 1'b0;
    done_n      = 1'b0;
    case (state)
      IDLE: begin
        // Bus turnaround: DIR must be low this cycle and last; no start on the done cycle.
        if (tx_start && !ulpi_dir && !dir_q && !done_q) begin
          if (pid_hs || pid_data) begin
            accept  = 1'b1;
            state_n = TXCMD;
          end else begin
            bad_pid = 1'b1;
          end
        end
      end
      TXCMD: begin
        ulpi_oe     = 1'b1;
        ulpi_data_o = {2'b01, 2'b00, pid_q};
        if (ulpi_dir) begin
          abort_n = 1'b1;
          state_n = IDLE;
        end else if (ulpi_nxt) begin
          if (!is_data_q)          state_n = STOP;
          else if (len_q == '0)    state_n = CRC_LO;
          else                     state_n = PAYLOAD;
        end
      end
      PAYLOAD: begin
        ulpi_oe     = 1'b1;
        ulpi_data_o = data_i;
        if (ulpi_dir) begin
          abort_n = 1'b1;
          state_n = IDLE;
        end else if (data_i_empty) begin
          ulpi_data_o = 8'hFF;
          ulpi_stp    = 1'b1;
          underrun    = 1'b1;
          state_n     = IDLE;
        end else if (ulpi_nxt) begin
          data_i_rd = 1'b1;
          take      = 1'b1;
          if ((count + LW'(1)) == len_q) state_n = CRC_LO;
        end
      end
      CRC_LO: begin
        ulpi_oe     = 1'b1;
        ulpi_data_o = ~crc[7:0];
        if (ulpi_dir) begin
          abort_n = 1'b1;
          state_n = IDLE;
        end else if (ulpi_nxt) begin
          state_n = CRC_HI;
        end
      end
      CRC_HI: begin
        ulpi_oe     = 1'b1;
        ulpi_data_o = ~crc[15:8];
        if (ulpi_dir) begin
          abort_n = 1'b1;
          state_n = IDLE;
        end else if (ulpi_nxt) begin
          state_n = STOP;
        end
      end
      STOP: begin
        ulpi_oe  = 1'b1;
        ulpi_stp = 1'b1;
        done_n   = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign tx_busy   = (state != IDLE);
  assign tx_done   = done_q;
  assign tx_abort  = abort_q;
  assign tx_err    = err_q;
  assign dbg_state = state;

endmodule
